wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator.sv | 192 +++++++++++++++++++
 tb/tb_wb_initiator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//
// Converts a single-outstanding valid/ready request into one Wishbone classic
// bus cycle. The result goes back through a valid/ready response channel.
// A request is accepted only in IDLE. The bus signals are registered at
// acceptance and held until the responder acks. The response is then held
// until it is consumed.
//
// Optional feature (macro WB_INITIATOR_TIMEOUT_EN):
//   A 16-bit watchdog closes a bus cycle that has gone TIMEOUT cycles without
//   ack and returns rsp_err=1. Without the macro the bus waits forever for
//   ack and rsp_err is always 0.
//
// Parameters:
//   TIMEOUT    cycles a bus cycle may stay open without ack (1..65535)
//
// Ports:
//   clk, reset_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready               request handshake
//   req_we/req_addr/req_data/req_sel  request payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_data/rsp_err                  read data (0 for writes/errors), timeout flag
//   o_wb_cyc/o_wb_stb/o_wb_we         Wishbone cycle, strobe, write enable
//   o_wb_addr/o_wb_data/o_wb_sel      Wishbone address, write data, byte select
//   i_wb_ack/i_wb_data                Wishbone acknowledge and read data
// ---------------------------------------------------------------------------
module wb_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        wb_cyc_reg, wb_cyc_next;
    logic        wb_we_reg, wb_we_next;
    logic [31:0] wb_addr_reg, wb_addr_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic [3:0]  wb_sel_reg, wb_sel_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        timeout_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt_reg, tmo_cnt_next;

    // The count equals the number of BUS cycles already spent without ack.
    // On the edge where it is TIMEOUT-1, the current cycle is the TIMEOUT-th.
    assign timeout_hit = (tmo_cnt_reg == TMO_LAST);

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        if (state_reg == IDLE) begin
            tmo_cnt_next = 16'd0;
        end else if (state_reg == BUS && !i_wb_ack && !timeout_hit) begin
            tmo_cnt_next = tmo_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg <= 16'd0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`else
    // No watchdog. TIMEOUT is only referenced here so that it does not
    // dangle in this build.
    localparam logic [15:0] TMO_UNUSED = 16'(TIMEOUT);
    logic unused_timeout;
    assign unused_timeout = ^TMO_UNUSED;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        wb_cyc_next    = wb_cyc_reg;
        wb_we_next     = wb_we_reg;
        wb_addr_next   = wb_addr_reg;
        wb_data_next   = wb_data_reg;
        wb_sel_next    = wb_sel_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                // req_ready is high throughout IDLE once out of reset.
                if (req_valid) begin
                    state_next   = BUS;
                    wb_cyc_next  = 1'b1;
                    wb_we_next   = req_we;
                    wb_addr_next = req_addr;
                    wb_data_next = req_data;
                    wb_sel_next  = req_sel;
                end
            end
            BUS: begin
                // Ack has priority over a timeout in the same cycle.
                if (i_wb_ack) begin
                    state_next     = RESP;
                    wb_cyc_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_data_next  = wb_we_reg ? 32'd0 : i_wb_data;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    wb_cyc_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_data_next  = 32'd0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                wb_cyc_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wb_cyc_reg    <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_addr_reg   <= 32'd0;
            wb_data_reg   <= 32'd0;
            wb_sel_reg    <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wb_cyc_reg    <= wb_cyc_next;
            wb_we_reg     <= wb_we_next;
            wb_addr_reg   <= wb_addr_next;
            wb_data_reg   <= wb_data_next;
            wb_sel_reg    <= wb_sel_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Gate with reset_n so that ready is low while reset is asserted.
    // The state is already IDLE during reset.
    assign req_ready = (state_reg == IDLE) && reset_n;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign o_wb_cyc  = wb_cyc_reg;
    assign o_wb_stb  = wb_cyc_reg;
    assign o_wb_we   = wb_we_reg;
    assign o_wb_addr = wb_addr_reg;
    assign o_wb_data = wb_data_reg;
    assign o_wb_sel  = wb_sel_reg;

endmodule

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
//
// Self-checking bench for wb_initiator with TIMEOUT=4. A table of
// transactions is run through a behavioural Wishbone responder whose ack
// delay is set per transaction. Expected responses are queued when a request
// is accepted and popped when the response is consumed. Hand-written
// sequences cover the reset state, ack while idle, and reset during a bus
// cycle. Build with WB_INITIATOR_TIMEOUT_EN defined to exercise the timeout
// expectations.
// ---------------------------------------------------------------------------
module tb_wb_initiator;

    localparam int TMO = 4;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int NV    = 8;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_sel = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack = 1'b0;
    logic [31:0] i_wb_data = 32'd0;

    wb_initiator #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_data (o_wb_data),
        .o_wb_sel  (o_wb_sel),
        .i_wb_ack  (i_wb_ack),
        .i_wb_data (i_wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ack_dly;   // ack during this BUS cycle (1-based), 0 = never
        logic [31:0] rdata;
        int          hold;      // cycles of rsp_ready=0 back-pressure
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_cyc;   // cycles o_wb_cyc is expected high
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t vecs [NV];
    rsp_t sb_q [$];

    int checks = 0;
    int errors = 0;

    // Responder state, updated on falling edges.
    int          resp_dly = 0;
    logic [31:0] resp_data = 32'd0;
    logic        ack_force = 1'b0;
    int          bus_cnt = 0;
    int          cyc_len = 0;
    logic        bus_unstable = 1'b0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = 32'd0, cap_data = 32'd0;
    logic [3:0]  cap_sel = 4'd0;

    always @(negedge clk) begin
        if (o_wb_cyc) begin
            bus_cnt = bus_cnt + 1;
            cyc_len = bus_cnt;
            if (bus_cnt == 1) begin
                bus_unstable = (o_wb_stb !== 1'b1);
                cap_we   = o_wb_we;
                cap_addr = o_wb_addr;
                cap_data = o_wb_data;
                cap_sel  = o_wb_sel;
            end else if (o_wb_stb !== 1'b1 || o_wb_we !== cap_we || o_wb_addr !== cap_addr ||
                         o_wb_data !== cap_data || o_wb_sel !== cap_sel) begin
                bus_unstable = 1'b1;
            end
        end else begin
            bus_cnt = 0;
        end
        i_wb_ack  = ack_force || (o_wb_cyc && resp_dly != 0 && bus_cnt == resp_dly);
        i_wb_data = resp_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel, input int dly,
                           input logic [31:0] rdata, input int hold);
        logic to;
        to = TMO_EN && (dly == 0 || dly > TMO);
        vecs[i].we       = we;
        vecs[i].addr     = addr;
        vecs[i].wdata    = wdata;
        vecs[i].sel      = sel;
        vecs[i].ack_dly  = dly;
        vecs[i].rdata    = rdata;
        vecs[i].hold     = hold;
        vecs[i].exp_err  = to;
        vecs[i].exp_data = (to || we) ? 32'd0 : rdata;
        vecs[i].exp_cyc  = to ? TMO : dly;
    endtask

    // Called at a point away from any clock edge with the DUT in IDLE.
    task automatic run_vec(input int i);
        vec_t        v;
        rsp_t        exp;
        int          n;
        logic        rr_bad;
        logic        hold_bad;
        logic [31:0] snap;
        v = vecs[i];
        resp_dly  = v.ack_dly;
        resp_data = v.rdata;
        check($sformatf("v%0d_req_ready_idle", i), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_data  = v.wdata;
        req_sel   = v.sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_q.push_back('{data: v.exp_data, err: v.exp_err});
        check($sformatf("v%0d_cyc_after_accept", i), 32'(o_wb_cyc), 32'd1);

        n = 0;
        rr_bad = 1'b0;
        while (!rsp_valid && n < LIMIT) begin
            if (req_ready) rr_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) begin
            check($sformatf("v%0d_rsp_wait_expired", i), 32'(n), 32'(v.exp_cyc));
            return;
        end
        check($sformatf("v%0d_latency", i), 32'(n), 32'(v.exp_cyc));
        check($sformatf("v%0d_cyc_len", i), 32'(cyc_len), 32'(v.exp_cyc));
        check($sformatf("v%0d_cyc_dropped", i), {31'd0, o_wb_cyc | o_wb_stb}, 32'd0);
        check($sformatf("v%0d_ready_low_in_bus", i), 32'(rr_bad), 32'd0);
        check($sformatf("v%0d_bus_stable", i), 32'(bus_unstable), 32'd0);
        check($sformatf("v%0d_bus_addr", i), cap_addr, v.addr);
        check($sformatf("v%0d_bus_data", i), cap_data, v.wdata);
        check($sformatf("v%0d_bus_sel_we", i), {27'd0, cap_sel, cap_we}, {27'd0, v.sel, v.we});

        // Back-pressure: hold rsp_ready low while a new request and a stray
        // ack are presented; neither may disturb the pending response.
        snap = rsp_data;
        hold_bad = 1'b0;
        if (v.hold > 0) begin
            req_valid = 1'b1;
            ack_force = 1'b1;
        end
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== snap || req_ready || o_wb_cyc) hold_bad = 1'b1;
        end
        ack_force = 1'b0;
        if (v.hold > 0) check($sformatf("v%0d_backpressure_hold", i), 32'(hold_bad), 32'd0);

        // Consume the response and compare with the scoreboard.
        rsp_ready = 1'b1;
        exp = sb_q.pop_front();
        check($sformatf("v%0d_rsp_data", i), rsp_data, exp.data);
        check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(exp.err));
        $display("txn %0d we=%0b addr=%h dly=%0d -> rsp_data=%h rsp_err=%0b cyc_len=%0d",
                 i, v.we, v.addr, v.ack_dly, rsp_data, rsp_err, cyc_len);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_valid_cleared", i), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_no_accept_on_consume", i), 32'(o_wb_cyc), 32'd0);
        check($sformatf("v%0d_ready_after_resp", i), 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic bad;

        set_vec(0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1,       32'hAAAA_5555, 0);
        set_vec(1, 1'b0, 32'h1000_0000, 32'h0000_0000, 4'hF, 3,       32'h1234_5678, 0);
        set_vec(2, 1'b0, 32'h2000_0010, 32'h5A5A_0000, 4'h3, 1,       32'hCAFE_F00D, 5);
        set_vec(3, 1'b1, 32'h0000_0004, 32'h0102_0304, 4'h1, 2,       32'hFFFF_FFFF, 1);
        set_vec(4, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, TMO,     32'h0BAD_C0DE, 0);
        set_vec(5, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'hC, TMO + 1, 32'h7777_8888, 2);
        set_vec(6, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'hF, 1000,    32'h1357_9BDF, 0);
        set_vec(7, 1'b1, 32'hFFFF_FFFC, 32'h2468_ACE0, 4'h8, 1000,    32'h0000_0000, 0);

        // Reset state.
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("reset_rsp", {rsp_valid, rsp_err, 30'd0} | rsp_data, 32'd0);
        check("reset_bus_regs", o_wb_addr | o_wb_data | {27'd0, o_wb_sel, o_wb_we}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Ack while idle must be ignored.
        ack_force = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid || o_wb_cyc || !req_ready) bad = 1'b1;
        end
        ack_force = 1'b0;
        @(posedge clk); #1;
        check("idle_ack_ignored", 32'(bad), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset in the second cycle of a pending read.
        resp_dly  = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h5000_0000;
        req_sel   = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midbus_cyc_open", 32'(o_wb_cyc), 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midbus_async_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("midbus_ready_low", 32'(req_ready), 32'd0);
        check("midbus_addr_cleared", o_wb_addr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid || o_wb_cyc || !req_ready) bad = 1'b1;
        end
        check("midbus_no_rsp_ready_high", 32'(bad), 32'd0);
        $display("txn reset_mid_bus -> rsp_valid=%0b req_ready=%0b", rsp_valid, req_ready);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
